// File: rtl/spis_pkg.sv
// Shared encodings for the SPI-slave register initiator: request ops, response
// status codes, register offsets and the initiator FSM state type.
package spis_pkg;

    localparam logic [1:0] OP_WR     = 2'b00;
    localparam logic [1:0] OP_RD     = 2'b01;
    localparam logic [1:0] OP_LAUNCH = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    localparam logic [15:0] ADDR_CMD    = 16'h0000;
    localparam logic [15:0] ADDR_STATUS = 16'h000C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_L_WR,
        S_L_GAP,
        S_L_POLL,
        S_L_STAT,
        S_RESP
    } state_t;

endpackage

// File: rtl/spis_reg_initiator.sv
// Register-bus initiator between the SPI-slave frame decoder and the register
// file: single write, single read, and command launch with go-bit polling.
module spis_reg_initiator
    import spis_pkg::*;
#(
    parameter int POLL_GAP  = 4,
    parameter int MAX_POLLS = 1024
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        write,
    output logic        read,
    output logic [15:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        busy
);

    localparam int              PW         = $clog2(MAX_POLLS + 1);
    localparam logic [PW-1:0]   POLL_LIMIT = PW'(MAX_POLLS);
    localparam logic [7:0]      GAP_LAST   = 8'(POLL_GAP - 1);

    state_t        state_q, state_d;
    logic [7:0]    gap_q, gap_d;
    logic [PW-1:0] poll_q, poll_d, poll_inc;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
    logic [15:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]    rsp_status_q, rsp_status_d;

    always_comb begin
        state_d      = state_q;
        gap_d        = gap_q;
        poll_d       = poll_q;
        write_d      = 1'b0;
        read_d       = 1'b0;
        addr_d       = 16'h0000;
        wdata_d      = 32'h0000_0000;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        // Saturating increment: the poll count never wraps past MAX_POLLS.
        poll_inc     = (poll_q == POLL_LIMIT) ? poll_q : poll_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    gap_d  = 8'd0;
                    poll_d = '0;
                    case (req_op)
                        OP_WR: begin
                            state_d = S_WR;
                            write_d = 1'b1;
                            addr_d  = req_addr;
                            wdata_d = req_wdata;
                        end
                        OP_RD: begin
                            state_d = S_RD;
                            read_d  = 1'b1;
                            addr_d  = req_addr;
                        end
                        OP_LAUNCH: begin
                            state_d = S_L_WR;
                            write_d = 1'b1;
                            addr_d  = ADDR_CMD;
                            wdata_d = {req_wdata[31:1], 1'b1};
                        end
                        default: begin
                            state_d      = S_RESP;
                            rsp_valid_d  = 1'b1;
                            rsp_rdata_d  = 32'h0000_0000;
                            rsp_status_d = ST_ILLEGAL;
                        end
                    endcase
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = 32'h0000_0000;
                rsp_status_d = ST_OK;
            end
            S_RD: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = rdata;
                rsp_status_d = ST_OK;
            end
            S_L_WR: begin
                state_d = S_L_GAP;
                gap_d   = 8'd0;
            end
            S_L_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_L_POLL;
                    read_d  = 1'b1;
                    addr_d  = ADDR_CMD;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            S_L_POLL: begin
                poll_d = poll_inc;
                if (!rdata[0]) begin
                    state_d = S_L_STAT;
                    read_d  = 1'b1;
                    addr_d  = ADDR_STATUS;
                end else if (poll_inc == POLL_LIMIT) begin
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = rdata;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    state_d = S_L_GAP;
                    gap_d   = 8'd0;
                end
            end
            S_L_STAT: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = rdata;
                rsp_status_d = ST_OK;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake flags follow the next state so they are valid the cycle it is entered.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            gap_q        <= 8'd0;
            poll_q       <= '0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 32'h0000_0000;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0000_0000;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            poll_q       <= poll_d;
            req_ready_q  <= req_ready_d;
            busy_q       <= busy_d;
            write_q      <= write_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign busy       = busy_q;
    assign write      = write_q;
    assign read       = read_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_spis_reg_initiator.sv
// Directed bench for spis_reg_initiator with a small register-file model that
// answers polls of the command register and logs every bus strobe.
module tb_spis_reg_initiator;

    localparam int POLL_GAP  = 4;
    localparam int MAX_POLLS = 8;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [15:0] req_addr = 16'h0000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        write;
    logic        read;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    spis_reg_initiator #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
        .aclk(aclk), .arst(arst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .write(write), .read(read), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    // Register model state and strobe log
    int          cyc = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          both_cnt = 0;
    int          n_polls = 0;
    int          wr_cyc = 0;
    int          acc_cyc = 0;
    int          rsp_cyc = 0;
    logic        armed = 1'b0;
    logic [15:0] last_wr_addr = 16'h0;
    logic [31:0] last_wr_data = 32'h0;
    logic [31:0] cmd_reg = 32'h0;
    logic [15:0] rd_addr_log [64];
    int          rd_cyc_log [64];
    int          clear_at = 0;
    int          poll_base = 0;
    logic        go;

    always_comb begin
        go = cmd_reg[0];
        if (clear_at != 0 && (n_polls - poll_base + 1) >= clear_at) go = 1'b0;
    end

    always_comb begin
        rdata = 32'hDEAD0000 | {16'h0000, addr};
        if (addr == 16'h0000)      rdata = {cmd_reg[31:1], go};
        else if (addr == 16'h0010) rdata = 32'h12345678;
        else if (addr == 16'h000C) rdata = 32'h00000055;
    end

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (write) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= addr;
            last_wr_data <= wdata;
            wr_cyc       <= cyc;
            if (addr == 16'h0000) cmd_reg <= wdata;
        end
        if (read) begin
            rd_addr_log[rd_cnt % 64] <= addr;
            rd_cyc_log[rd_cnt % 64]  <= cyc;
            rd_cnt <= rd_cnt + 1;
            if (addr == 16'h0000) n_polls <= n_polls + 1;
        end
        if (write && read) both_cnt <= both_cnt + 1;
        if (req_valid && req_ready) begin
            acc_cyc <= cyc;
            armed   <= 1'b1;
        end else if (rsp_valid && armed) begin
            rsp_cyc <= cyc;
            armed   <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d);
        int k;
        k = 0;
        @(negedge aclk);
        req_op = op; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (!req_ready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        if (!req_ready) check_eq("req_accept_timeout", 32'(req_ready), 32'd1);
        @(negedge aclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        int k;
        k = 0;
        while (!rsp_valid && k < budget) begin
            @(negedge aclk);
            k++;
        end
        if (!rsp_valid) check_eq("rsp_wait_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic consume(input string tag);
        @(negedge aclk);
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_req_ready_rise"}, 32'(req_ready), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_write"}, 32'(write), 32'd0);
        check_eq({tag, "_read"}, 32'(read), 32'd0);
        check_eq({tag, "_addr"}, 32'(addr), 32'd0);
        check_eq({tag, "_wdata"}, wdata, 32'd0);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int wr0, rd0;

    initial begin
        // Reset state
        repeat (3) @(negedge aclk);
        check_idle_outputs("reset");
        check_eq("reset_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("reset_rsp_status", 32'(rsp_status), 32'd0);
        arst = 1'b0;
        @(negedge aclk);

        // Single write
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(2'b00, 16'h0044, 32'h0000000F);
        wait_rsp(20);
        check_eq("wr_status", 32'(rsp_status), 32'd0);
        check_eq("wr_rdata", rsp_rdata, 32'd0);
        check_eq("wr_busy", 32'(busy), 32'd1);
        consume("wr");
        check_eq("wr_count", 32'(wr_cnt - wr0), 32'd1);
        check_eq("wr_reads", 32'(rd_cnt - rd0), 32'd0);
        check_eq("wr_addr", 32'(last_wr_addr), 32'h44);
        check_eq("wr_data", last_wr_data, 32'h0000000F);
        check_eq("wr_strobe_lat", 32'(wr_cyc - acc_cyc), 32'd1);
        check_eq("wr_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd2);

        // Single read
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(2'b01, 16'h0010, 32'h0);
        wait_rsp(20);
        check_eq("rd_rdata", rsp_rdata, 32'h12345678);
        check_eq("rd_status", 32'(rsp_status), 32'd0);
        consume("rd");
        check_eq("rd_count", 32'(rd_cnt - rd0), 32'd1);
        check_eq("rd_writes", 32'(wr_cnt - wr0), 32'd0);
        check_eq("rd_addr", 32'(rd_addr_log[rd0 % 64]), 32'h10);
        check_eq("rd_strobe_lat", 32'(rd_cyc_log[rd0 % 64] - acc_cyc), 32'd1);
        check_eq("rd_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd2);

        // Launch: go bit clears on the third poll
        wr0 = wr_cnt; rd0 = rd_cnt;
        clear_at = 3; poll_base = n_polls;
        do_req(2'b10, 16'h1234, 32'hA0000000);
        wait_rsp(200);
        check_eq("ln_rdata", rsp_rdata, 32'h00000055);
        check_eq("ln_status", 32'(rsp_status), 32'd0);
        consume("ln");
        check_eq("ln_writes", 32'(wr_cnt - wr0), 32'd1);
        check_eq("ln_wr_addr", 32'(last_wr_addr), 32'h0);
        check_eq("ln_wr_data", last_wr_data, 32'hA0000001);
        check_eq("ln_reads", 32'(rd_cnt - rd0), 32'd4);
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("ln_poll%0d_addr", i), 32'(rd_addr_log[(rd0 + i) % 64]), 32'h0);
        check_eq("ln_stat_addr", 32'(rd_addr_log[(rd0 + 3) % 64]), 32'h000C);
        check_eq("ln_gap0", 32'(rd_cyc_log[rd0 % 64] - wr_cyc), 32'(POLL_GAP + 1));
        check_eq("ln_gap1", 32'(rd_cyc_log[(rd0 + 1) % 64] - rd_cyc_log[rd0 % 64]), 32'(POLL_GAP + 1));
        check_eq("ln_gap2", 32'(rd_cyc_log[(rd0 + 2) % 64] - rd_cyc_log[(rd0 + 1) % 64]), 32'(POLL_GAP + 1));
        check_eq("ln_stat_gap", 32'(rd_cyc_log[(rd0 + 3) % 64] - rd_cyc_log[(rd0 + 2) % 64]), 32'd1);

        // Launch timeout: go bit never clears
        wr0 = wr_cnt; rd0 = rd_cnt;
        clear_at = 0; poll_base = n_polls;
        do_req(2'b10, 16'h0000, 32'h12340000);
        wait_rsp(300);
        check_eq("to_status", 32'(rsp_status), 32'd1);
        check_eq("to_rdata", rsp_rdata, 32'h12340001);
        consume("to");
        check_eq("to_reads", 32'(rd_cnt - rd0), 32'(MAX_POLLS));
        check_eq("to_last_addr", 32'(rd_addr_log[(rd0 + MAX_POLLS - 1) % 64]), 32'h0);
        check_eq("to_both", 32'(both_cnt), 32'd0);

        // Illegal op with backpressure
        wr0 = wr_cnt; rd0 = rd_cnt;
        do_req(2'b11, 16'h0099, 32'hFFFFFFFF);
        wait_rsp(20);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("il_valid_c%0d", i), 32'(rsp_valid), 32'd1);
            check_eq($sformatf("il_status_c%0d", i), 32'(rsp_status), 32'd2);
            check_eq($sformatf("il_rdata_c%0d", i), rsp_rdata, 32'd0);
            check_eq($sformatf("il_req_ready_c%0d", i), 32'(req_ready), 32'd0);
            @(negedge aclk);
        end
        consume("il");
        check_eq("il_writes", 32'(wr_cnt - wr0), 32'd0);
        check_eq("il_reads", 32'(rd_cnt - rd0), 32'd0);

        // Reset asserted during the poll gap of a launch
        clear_at = 0; poll_base = n_polls;
        do_req(2'b10, 16'h0000, 32'h00000000);
        @(negedge aclk);
        check_eq("rst_busy_before", 32'(busy), 32'd1);
        arst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        @(negedge aclk);
        arst = 1'b0;
        repeat (POLL_GAP + 3) @(negedge aclk);
        check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("midrst_no_busy", 32'(busy), 32'd0);

        wr0 = wr_cnt;
        do_req(2'b00, 16'h0020, 32'hCAFEF00D);
        wait_rsp(20);
        check_eq("post_status", 32'(rsp_status), 32'd0);
        consume("post");
        check_eq("post_writes", 32'(wr_cnt - wr0), 32'd1);
        check_eq("post_wr_addr", 32'(last_wr_addr), 32'h20);
        check_eq("post_wr_data", last_wr_data, 32'hCAFEF00D);
        check_eq("post_rsp_lat", 32'(rsp_cyc - acc_cyc), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "global timeout");
    end

endmodule
